// File: rtl/booth_pp_acc_if.sv
// Bus between a Booth partial-product source and booth_pp_accumulator.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. The source holds in_valid and its payload (row0..row7, add)
// steady until that edge. The accumulator holds out_valid and product steady
// until out_ready is seen high on an edge. ready may depend on valid, and
// valid never depends on ready.
interface booth_pp_acc_if #(
  parameter int BITWIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BITWIDTH:0]       row0;
  logic [BITWIDTH:0]       row1;
  logic [BITWIDTH:0]       row2;
  logic [BITWIDTH:0]       row3;
  logic [BITWIDTH:0]       row4;
  logic [BITWIDTH:0]       row5;
  logic [BITWIDTH:0]       row6;
  logic [BITWIDTH:0]       row7;
  logic [BITWIDTH/2-1:0]   add;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*BITWIDTH-1:0]   product;
  logic                    busy;

  // Source of partial products and consumer of the product
  modport master (
    output in_valid, row0, row1, row2, row3, row4, row5, row6, row7, add,
    output out_ready,
    input  in_ready, out_valid, product, busy
  );

  // The accumulator
  modport slave (
    input  in_valid, row0, row1, row2, row3, row4, row5, row6, row7, add,
    input  out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Multi-cycle accumulator for radix-4 Booth partial-product rows.
// Each row is {inverted sign, value}; add[j] is the +1 negation correction
// for row j, and row j carries weight 4^j. The product is the modulo-2^32 sum.
//
// Optional feature macro: BOOTH_ACC_DUAL_ROW_EN
//   undefined : one row per ACCUM cycle, 8 cycles, one 32-bit adder
//   defined   : two rows per ACCUM cycle, 4 cycles, two adders
// Results are identical in both builds; only latency differs.
module booth_pp_accumulator #(
  parameter int BITWIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_pp_acc_if.slave      bus,
  output logic [1:0]         state_dbg
);

  localparam int RW   = BITWIDTH + 1;
  localparam int ROWS = BITWIDTH / 2;
  localparam int PW   = 2 * BITWIDTH;
  localparam int CW   = $clog2(ROWS);

`ifdef BOOTH_ACC_DUAL_ROW_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS / 2 - 1);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_next;
  logic [RW-1:0]   rows_q [ROWS];
  logic [ROWS-1:0] add_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [RW-1:0]   row_in [ROWS];

  assign row_in[0] = bus.row0;
  assign row_in[1] = bus.row1;
  assign row_in[2] = bus.row2;
  assign row_in[3] = bus.row3;
  assign row_in[4] = bus.row4;
  assign row_in[5] = bus.row5;
  assign row_in[6] = bus.row6;
  assign row_in[7] = bus.row7;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state_q;

  // Weighted 32-bit term of one row: restore the true sign bit, sign-extend,
  // add the negation correction, then shift by 2*idx (weight 4^idx).
  function automatic logic [PW-1:0] row_term(
    input logic [RW-1:0] row,
    input logic          corr,
    input logic [CW-1:0] idx
  );
    logic [RW-1:0] val;
    logic [PW-1:0] ext;
    val = {~row[RW-1], row[RW-2:0]};
    ext = {{(PW-RW){val[RW-1]}}, val} + {{(PW-1){1'b0}}, corr};
    return ext << {idx, 1'b0};
  endfunction

`ifdef BOOTH_ACC_DUAL_ROW_EN
  logic [CW-1:0] idx_lo;
  logic [CW-1:0] idx_hi;

  // Next accumulator value: rows 2k and 2k+1 where k is the counter
  always_comb begin
    idx_lo   = {cnt_q[CW-2:0], 1'b0};
    idx_hi   = {cnt_q[CW-2:0], 1'b1};
    acc_next = acc_q
             + row_term(rows_q[idx_lo], add_q[idx_lo], idx_lo)
             + row_term(rows_q[idx_hi], add_q[idx_hi], idx_hi);
  end
`else
  // Next accumulator value: the single row selected by the counter
  always_comb begin
    acc_next = acc_q + row_term(rows_q[cnt_q], add_q[cnt_q], cnt_q);
  end
`endif

  // Control FSM with registered handshake outputs, operand capture and accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      add_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int j = 0; j < ROWS; j++) rows_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int j = 0; j < ROWS; j++) rows_q[j] <= row_in[j];
            add_q      <= bus.add;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_next;
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Testbench for booth_pp_accumulator: directed vectors, backpressure, reset
// abort, random raw rows and random Booth-encoded operand pairs. Expected
// results come from plain arithmetic (row sum, or signed X*Y).
module tb_booth_pp_accumulator;

  localparam int W = 16;
`ifdef BOOTH_ACC_DUAL_ROW_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  typedef logic [7:0][16:0] rows_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  booth_pp_acc_if #(.BITWIDTH(W)) bus ();

  booth_pp_accumulator #(.BITWIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int unsigned acc_cyc_q[$];
  int          rdy_mode = 2;   // 0: hold low, 1: hold high, 2: random
  logic        prev_ov = 1'b0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [31:0] ref_sum(input rows_t r, input logic [7:0] a);
    longint s;
    logic signed [16:0] v;
    s = 0;
    for (int j = 0; j < 8; j++) begin
      v = {~r[j][16], r[j][15:0]};
      s += (longint'(v) + longint'(a[j])) * (longint'(1) << (2 * j));
    end
    return s[31:0];
  endfunction

  // Radix-4 Booth row generator: digit d in {-2..2}; negative digits are
  // one's-complemented with the +1 carried in add[j].
  function automatic void booth_gen(input logic [15:0] x, input logic [15:0] y,
                                    output rows_t r, output logic [7:0] a);
    logic [16:0]        yx;
    logic signed [16:0] xe, m, v;
    int                 d;
    yx = {y, 1'b0};
    xe = {x[15], x};
    for (int j = 0; j < 8; j++) begin
      d = 0;
      if (yx[2*j+2]) d -= 2;
      if (yx[2*j+1]) d += 1;
      if (yx[2*j])   d += 1;
      if (d == 2 || d == -2) m = xe <<< 1;
      else if (d == 0)       m = 17'sd0;
      else                   m = xe;
      v    = (d < 0) ? ~m : m;
      a[j] = (d < 0);
      r[j] = {~v[16], v[15:0]};
    end
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      prev_ov  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc_q.push_back(cyc + 1);
      if (bus.out_valid && !prev_ov) begin
        if (acc_cyc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: out_valid=1, required 0");
        end else begin
          check("latency", cyc - acc_cyc_q.pop_front(), LAT);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_product: got 0x%08h, required no output", bus.product);
        end else begin
          check("product", bus.product, exp_q.pop_front());
        end
      end
      if (exp_q.size() != 0 && !bus.out_valid) wait_cnt++;
      else wait_cnt = 0;
      if (wait_cnt > 40) begin
        n_tests++; n_fail++;
        $display("FAIL result_timeout: out_valid=0 for 40 cycles, required 1");
        void'(exp_q.pop_front());
        wait_cnt = 0;
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input rows_t r, input logic [7:0] a, input logic [31:0] exp);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=0, required 1");
      return;
    end
    bus.row0 = r[0]; bus.row1 = r[1]; bus.row2 = r[2]; bus.row3 = r[3];
    bus.row4 = r[4]; bus.row5 = r[5]; bus.row6 = r[6]; bus.row7 = r[7];
    bus.add  = a;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.row0 = 17'($urandom); bus.row1 = 17'($urandom);
    bus.row2 = 17'($urandom); bus.row3 = 17'($urandom);
    bus.row4 = 17'($urandom); bus.row5 = 17'($urandom);
    bus.row6 = 17'($urandom); bus.row7 = 17'($urandom);
    bus.add  = 8'($urandom);
  endtask

  task automatic wait_out_valid();
    int guard;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  rows_t       rz, rw, rn;
  rows_t       rr;
  logic [7:0]  ar;
  logic [31:0] held;
  logic [15:0] x, y;
  logic signed [31:0] p;
  int          ov_seen;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.add = '0;
    bus.row0 = '0; bus.row1 = '0; bus.row2 = '0; bus.row3 = '0;
    bus.row4 = '0; bus.row5 = '0; bus.row6 = '0; bus.row7 = '0;
    rdy_mode = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy",      {31'd0, bus.busy},      32'd0);
    check("reset_product",   bus.product,            32'd0);
    rst_n = 1'b1;

    // Zero
    for (int j = 0; j < 8; j++) rz[j] = 17'h10000;
    send(rz, 8'h00, 32'h0000_0000);
    // Weighting
    rw = rz; rw[0] = 17'h10007; rw[1] = 17'h10001; rw[7] = 17'h10001;
    send(rw, 8'h00, 32'h0000_400B);
    // Negative and correction
    rn = rz; rn[0] = 17'h0FFFE;
    send(rn, 8'h01, 32'hFFFF_FFFF);
    rn[0] = 17'h0FFFF;
    send(rn, 8'h01, 32'h0000_0000);
    drain();

    // Backpressure in DONE
    rdy_mode = 0;
    @(posedge clk); #1;
    send(rw, 8'h00, 32'h0000_400B);
    wait_out_valid();
    held = bus.product;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_product",   bus.product,            held);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_busy",      {31'd0, bus.busy},      32'd1);
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    drain();

    // Reset at the third accumulate cycle
    send(rw, 8'h00, 32'h0000_400B);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_accum_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_product",   bus.product,            32'd0);
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_busy",      {31'd0, bus.busy},      32'd0);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen++;
    end
    check("abort_no_output", ov_seen, 0);
    send(rw, 8'h00, 32'h0000_400B);
    drain();

    // Random raw rows with random out_ready
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 8; j++) rr[j] = 17'($urandom);
      ar = 8'($urandom);
      send(rr, ar, ref_sum(rr, ar));
    end
    drain();

    // Booth-encoded operand pairs: corners, then random
    for (int i = 0; i < 2006; i++) begin
      case (i)
        0:       begin x = 16'h8000; y = 16'h8000; end
        1:       begin x = 16'h8000; y = 16'h7FFF; end
        2:       begin x = 16'h7FFF; y = 16'h7FFF; end
        3:       begin x = 16'h0000; y = 16'hFFFF; end
        4:       begin x = 16'hFFFF; y = 16'hFFFF; end
        5:       begin x = 16'h1234; y = 16'h0000; end
        default: begin x = 16'($urandom); y = 16'($urandom); end
      endcase
      p = $signed(x) * $signed(y);
      booth_gen(x, y, rr, ar);
      send(rr, ar, p);
    end
    drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
